// File: rtl/demux8_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux8_deser_if
//  Purpose  : Serial-in / word-out bundle for the demux8_deser return path.
//  Revision : 1.0  initial release
// ============================================================================
interface demux8_deser_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             bit_in;
    logic             bit_valid;
    logic             sync;
    logic             ovr_clr;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic             overrun;

    // Producer/consumer side of the block
    modport master (
        output bit_in, bit_valid, sync, ovr_clr, out_ready,
        input  d, out_valid, sel, overrun
    );

    // Deserialiser side
    modport slave (
        input  bit_in, bit_valid, sync, ovr_clr, out_ready,
        output d, out_valid, sel, overrun
    );
endinterface
`default_nettype wire

// File: rtl/demux8_deser.sv
`default_nettype none
// ============================================================================
//  Module   : demux8_deser
//  Purpose  : Counter-driven serial-to-parallel demux with one-word output
//             buffer, valid/ready handshake and sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
module demux8_deser #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire             clk,
    input  wire             rst,
    demux8_deser_if.slave   bus_io
);

    localparam logic [SEL_W-1:0] c_LAST    = SEL_W'(WIDTH - 1);
    localparam logic [0:0]       c_S_EMPTY = 1'b0;
    localparam logic [0:0]       c_S_FULL  = 1'b1;

    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [WIDTH-1:0] asm_q,     asm_d;
    logic [WIDTH-1:0] d_q,       d_d;
    logic [0:0]       state_q,   state_d;
    logic             overrun_q, overrun_d;

    logic [SEL_W-1:0] w_eff_sel;
    logic [SEL_W-1:0] w_slot;
    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_load_d;
    logic             w_ovr_set;

    // sync makes this edge behave as slot 0 of a fresh, empty frame
    always_comb begin
        w_eff_sel  = bus_io.sync ? '0 : sel_q;
        w_slot     = MSB_FIRST ? (c_LAST - w_eff_sel) : w_eff_sel;
        w_word     = bus_io.sync ? '0 : asm_q;
        if (bus_io.bit_valid) begin
            w_word[w_slot] = bus_io.bit_in;
        end
        w_complete = bus_io.bit_valid && (w_eff_sel == c_LAST);
    end

    always_comb begin
        sel_d = w_eff_sel;
        asm_d = w_word;
        if (bus_io.bit_valid) begin
            sel_d = w_eff_sel + SEL_W'(1);
            if (w_complete) begin
                asm_d = '0;
            end
        end
    end

    // Output buffer FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_S_EMPTY;
            sel_q     <= '0;
            asm_q     <= '0;
            d_q       <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            asm_q     <= asm_d;
            d_q       <= d_d;
            overrun_q <= overrun_d;
        end
    end

    // Output buffer FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_EMPTY: if (w_complete) state_d = c_S_FULL;
            c_S_FULL:  if (bus_io.out_ready && !w_complete) state_d = c_S_EMPTY;
            default:   state_d = c_S_EMPTY;
        endcase
    end

    // Output buffer FSM: load / drop decisions
    always_comb begin
        w_load_d  = w_complete && ((state_q == c_S_EMPTY) || bus_io.out_ready);
        w_ovr_set = w_complete && (state_q == c_S_FULL) && !bus_io.out_ready;
        d_d       = w_load_d ? w_word : d_q;
        overrun_d = w_ovr_set ? 1'b1 : (bus_io.ovr_clr ? 1'b0 : overrun_q);
    end

    assign bus_io.d         = d_q;
    assign bus_io.out_valid = (state_q == c_S_FULL);
    assign bus_io.sel       = sel_q;
    assign bus_io.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_demux8_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux8_deser
//  Purpose  : Directed self-checking bench for demux8_deser (LSB-first).
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux8_deser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    demux8_deser_if #(.WIDTH(8), .SEL_W(3)) bus ();

    demux8_deser #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        tick();
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] v;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.ovr_clr   = 1'b0;
        bus.out_ready = 1'b0;

        // 1. reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_d",       32'(bus.d),         32'h00);
        chk("rst_valid",   32'(bus.out_valid), 32'h0);
        chk("rst_sel",     32'(bus.sel),       32'h0);
        chk("rst_overrun", 32'(bus.overrun),   32'h0);

        // 2. single frame 0x96, consumer always ready
        bus.out_ready = 1'b1;
        v = 8'h96;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            chk("f96_sel",   32'(bus.sel),       32'((i + 1) % 8));
            chk("f96_valid", 32'(bus.out_valid), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("f96_d", 32'(bus.d), 32'h96);
        tick();
        chk("f96_pulse_end", 32'(bus.out_valid), 32'h0);
        chk("f96_d_hold",    32'(bus.d),         32'h96);

        // 3. stall, overrun, clear
        bus.out_ready = 1'b0;
        send_byte(8'h3C);
        chk("f3c_valid", 32'(bus.out_valid), 32'h1);
        chk("f3c_d",     32'(bus.d),         32'h3C);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("f3c_stable", 32'(bus.d), 32'h3C);
        for (int i = 2; i < 8; i++) send_bit(1'b1);
        chk("ovr_d",       32'(bus.d),         32'h3C);
        chk("ovr_valid",   32'(bus.out_valid), 32'h1);
        chk("ovr_flag",    32'(bus.overrun),   32'h1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr",     32'(bus.overrun),   32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'h0);

        // 4. back-to-back frames, zero bubble
        send_byte(8'hA5);
        chk("fa5_valid", 32'(bus.out_valid), 32'h1);
        chk("fa5_d",     32'(bus.d),         32'hA5);
        v = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            chk("f5a_valid", 32'(bus.out_valid), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("f5a_d",     32'(bus.d),       32'h5A);
        chk("b2b_noovr", 32'(bus.overrun), 32'h0);

        // 5. sync mid-frame with a bit on the same edge
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("pre_sync_sel", 32'(bus.sel), 32'h3);
        bus.sync = 1'b1;
        send_bit(1'b1);
        bus.sync = 1'b0;
        chk("sync_sel",   32'(bus.sel),       32'h1);
        chk("sync_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        chk("sync_valid2", 32'(bus.out_valid), 32'h1);
        chk("sync_d",      32'(bus.d),         32'h01);

        // sync without a bit only restarts the frame
        send_bit(1'b1);
        send_bit(1'b1);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        chk("sync_only_sel", 32'(bus.sel), 32'h0);

        // 6. gapped frame 0x96
        v = 8'h96;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (i == 7) begin
                chk("gap_valid", 32'(bus.out_valid), 32'h1);
                chk("gap_d",     32'(bus.d),         32'h96);
            end
            tick();
            chk("gap_sel_hold", 32'(bus.sel), 32'((i + 1) % 8));
        end
        chk("gap_d_after", 32'(bus.d), 32'h96);

        // overrun set beats simultaneous clear
        bus.out_ready = 1'b0;
        send_byte(8'h5A);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        bus.ovr_clr = 1'b1;
        send_bit(1'b1);
        bus.ovr_clr = 1'b0;
        chk("set_wins", 32'(bus.overrun), 32'h1);
        chk("set_wins_d", 32'(bus.d), 32'h5A);

        // reset after bit 5 of a frame
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("mid_sel", 32'(bus.sel), 32'h5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_d",       32'(bus.d),         32'h00);
        chk("mrst_valid",   32'(bus.out_valid), 32'h0);
        chk("mrst_sel",     32'(bus.sel),       32'h0);
        chk("mrst_overrun", 32'(bus.overrun),   32'h0);
        bus.out_ready = 1'b1;
        send_byte(8'h80);
        chk("post_rst_d",     32'(bus.d),         32'h80);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
